// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around a combinational ALU: EX operand register,
// RES result register, 4-entry register file with retire-to-issue forwarding.
module alu_issue_wb #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [3:0]        ins_op,
  input  logic [RA_W-1:0]   ins_ra,
  input  logic [RA_W-1:0]   ins_rb,
  input  logic [RA_W-1:0]   ins_rd,
  input  logic              ins_we,
  input  logic              ins_imm_en,
  input  logic [DATA_W-1:0] ins_imm,
  output logic [DATA_W-1:0] in_a,
  output logic [DATA_W-1:0] in_b,
  output logic [3:0]        opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_carry,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic              ex_valid_q;
  logic              ex_we_q;
  logic [RA_W-1:0]   ex_rd_q;
  logic [DATA_W-1:0] in_a_q, in_b_q;
  logic [3:0]        op_q;
  logic              res_valid_q, res_zero_q, res_carry_q;
  logic [DATA_W-1:0] res_data_q;
  logic              flag_z_q, flag_c_q;

  logic              ex_adv, retire, accept, rf_wr;
  logic [DATA_W-1:0] op_a_d, op_b_d;

  assign ex_adv    = !res_valid_q || res_ready;
  assign ins_ready = !ex_valid_q || ex_adv;
  assign accept    = ins_valid && ins_ready;
  assign retire    = ex_valid_q && ex_adv;
  assign rf_wr     = retire && ex_we_q;

  // The retiring write lands on the same edge as the issue read, so bypass it.
  always_comb begin
    op_a_d = rf_q[ins_ra];
    op_b_d = rf_q[ins_rb];
    if (rf_wr && (ex_rd_q == ins_ra)) op_a_d = alu_out;
    if (rf_wr && (ex_rd_q == ins_rb)) op_b_d = alu_out;
    if (ins_imm_en)                   op_b_d = ins_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_wr) begin
      rf_q[ex_rd_q] <= alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_rd_q    <= '0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      op_q       <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_we_q    <= ins_we;
      ex_rd_q    <= ins_rd;
      in_a_q     <= op_a_d;
      in_b_q     <= op_b_d;
      op_q       <= ins_op;
    end else if (ex_adv) begin
      ex_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else if (retire) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_out;
      res_zero_q  <= alu_zero;
      res_carry_q <= alu_carry;
      flag_z_q    <= alu_zero;
      flag_c_q    <= alu_carry;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign in_a      = in_a_q;
  assign in_b      = in_b_q;
  assign opcode    = op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a stub ALU: op 0 passes in_b,
// op 5 computes in_a^in_b; zero = (out==0), carry = out[7].
module tb_alu_issue_wb;
  localparam int DW = 8;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [3:0]    ins_op = '0;
  logic [RW-1:0] ins_ra = '0, ins_rb = '0, ins_rd = '0;
  logic          ins_we = 1'b0, ins_imm_en = 1'b0;
  logic [DW-1:0] ins_imm = '0;
  logic [DW-1:0] in_a, in_b;
  logic [3:0]    opcode;
  logic [DW-1:0] alu_out;
  logic          alu_zero, alu_carry;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          res_zero, res_carry, flag_z, flag_c;
  logic [RW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          z;
    logic          c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   stalls = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (opcode)
      4'h0:    alu_out = in_b;
      4'h5:    alu_out = in_a ^ in_b;
      default: alu_out = in_a;
    endcase
  end
  assign alu_zero  = (alu_out == '0);
  assign alu_carry = alu_out[7];

  alu_issue_wb #(.DATA_W(DW), .NREG(4), .RA_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_ra(ins_ra), .ins_rb(ins_rb), .ins_rd(ins_rd), .ins_we(ins_we),
    .ins_imm_en(ins_imm_en), .ins_imm(ins_imm),
    .in_a(in_a), .in_b(in_b), .opcode(opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry),
    .flag_z(flag_z), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {24'd0, res_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          $display("result data=%02h zero=%0b carry=%0b (exp %02h %0b %0b)",
                   res_data, res_zero, res_carry, e.d, e.z, e.c);
          chk("res_data", {24'd0, res_data}, {24'd0, e.d});
          chk("res_zero", {31'd0, res_zero}, {31'd0, e.z});
          chk("res_carry", {31'd0, res_carry}, {31'd0, e.c});
          chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
          chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
        end
      end
    end
  end

  // Drives one instruction starting at a negedge and returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic we, input logic imm_en,
                       input logic [7:0] imm, input logic [7:0] ed, input logic ez,
                       input logic ec, input logic push);
    int guard;
    exp_t e;
    @(negedge clk);
    ins_op = op; ins_ra = ra; ins_rb = rb; ins_rd = rd;
    ins_we = we; ins_imm_en = imm_en; ins_imm = imm; ins_valid = 1'b1;
    #1;
    guard = 0;
    while (!ins_ready && guard < 50) begin
      stalls++;
      guard++;
      @(negedge clk);
      #1;
    end
    if (!ins_ready) chk("ins_ready_timeout", 32'd0, 32'd1);
    if (push) begin
      e.d = ed; e.z = ez; e.c = ec;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    $display("issue op=%0h ra=%0d rb=%0d rd=%0d we=%0b imm_en=%0b imm=%02h", op, ra, rb, rd, we, imm_en, imm);
  endtask

  task automatic idle();
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || res_valid) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #3;
    chk("drain_timeout", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic dbg_chk(input string name, input logic [1:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    chk(name, {24'd0, dbg_data}, {24'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_in_a", {24'd0, in_a}, 32'd0);
    chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ins_ready", {31'd0, ins_ready}, 32'd1);

    // Preload through pass-through op
    issue(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1);
    issue(4'h0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1);
    idle();
    drain();
    dbg_chk("dbg_r0_pre", 2'd0, 8'h3C);
    dbg_chk("dbg_r1_pre", 2'd1, 8'hA5);

    // r2 = r0^r1 then dependent r3 = r2^r2 back-to-back
    stalls = 0;
    issue(4'h5, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b1);
    issue(4'h5, 2'd2, 2'd2, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("fwd_in_a", {24'd0, in_a}, 32'h99);
    chk("fwd_in_b", {24'd0, in_b}, 32'h99);
    chk("dep_no_stall", stalls, 32'd0);
    idle();
    drain();
    dbg_chk("dbg_r2", 2'd2, 8'h99);
    dbg_chk("dbg_r3", 2'd3, 8'h00);

    // Backpressure with two queued instructions and a third waiting
    @(negedge clk);
    res_ready = 1'b0;
    issue(4'h5, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b1);
    issue(4'h5, 2'd3, 2'd1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1);
    fork
      issue(4'h5, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
      begin
        @(negedge clk);
        #1;
        chk("bp_ins_ready", {31'd0, ins_ready}, 32'd0);
        chk("bp_in_a0", {24'd0, in_a}, 32'h99);
        chk("bp_in_b0", {24'd0, in_b}, 32'hA5);
        chk("bp_res0", {24'd0, res_data}, 32'h99);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_in_a1", {24'd0, in_a}, 32'h99);
        chk("bp_in_b1", {24'd0, in_b}, 32'hA5);
        chk("bp_res1", {24'd0, res_data}, 32'h99);
        chk("bp_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        res_ready = 1'b1;
      end
    join
    idle();
    drain();
    dbg_chk("dbg_r3_bp", 2'd3, 8'h3C);
    dbg_chk("dbg_r2_bp", 2'd2, 8'h00);

    // Compare-style op without register write
    issue(4'h5, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b1);
    idle();
    drain();
    dbg_chk("dbg_r0_nowe", 2'd0, 8'h3C);

    // Reset while EX and RES both hold work
    @(negedge clk);
    res_ready = 1'b0;
    issue(4'h0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
    issue(4'h0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0);
    idle();
    #1;
    chk("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    chk("pre_rst_in_b", {24'd0, in_b}, 32'h11);
    dbg_chk("pre_rst_r1", 2'd1, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("async_res_valid", {31'd0, res_valid}, 32'd0);
    chk("async_res_data", {24'd0, res_data}, 32'd0);
    chk("async_ex_ops", {20'd0, opcode, in_a, in_b}, 32'd0);
    chk("async_flags", {30'd0, flag_z, flag_c}, 32'd0);
    for (int i = 0; i < 4; i++) dbg_chk("async_rf", i[1:0], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_result", {31'd0, res_valid}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
